// File: rtl/vsync.sv
// ---------------------------------------------------------------------------
// vsync -- vertical timing generator for the 640x480 VGA raster.
//
// Sits directly behind the horizontal timing block and advances one scanline
// every clock on which that block's end-of-scanline strobe is high. It counts
// scanlines per frame and produces the vertical sync pulse, the frame-buffer
// pixel row (each row spans LINES_PER_ROW scanlines), a vertical
// display-active flag and a one-clock frame-start strobe.
//
// Ports:
//   clk          in   1  system clock, shared with the horizontal block
//   reset        in   1  synchronous, active-low reset
//   line_end     in   1  high on the last clock of each scanline
//   VPIXEL       out  7  pixel row 0..VPIXEL_MAX, 0 outside the display
//   VGA_VSYNC    out  1  vertical sync, active-low
//   v_active     out  1  high while in the vertical display region
//   frame_start  out  1  one-clock strobe on the first clock of each frame
//   frame_cnt    out  8  frame counter, wraps 255 -> 0
//                        (present only when VSYNC_FRAME_CNT_EN is defined)
//
// Optional build macro: VSYNC_FRAME_CNT_EN adds the frame_cnt port.
// ---------------------------------------------------------------------------
module vsync #(
    parameter int V_PULSE       = 2,
    parameter int V_BP          = 29,
    parameter int V_DISP        = 480,
    parameter int V_FP          = 10,
    parameter int LINES_PER_ROW = 5,
    parameter int VPIXEL_MAX    = 95
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_end,
    output logic [6:0] VPIXEL,
    output logic       VGA_VSYNC,
    output logic       v_active,
    output logic       frame_start
`ifdef VSYNC_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    // Line numbers at which each region begins, plus the last line of a frame.
    localparam logic [9:0] LINE_BP   = 10'(V_PULSE);
    localparam logic [9:0] LINE_DISP = 10'(V_PULSE + V_BP);
    localparam logic [9:0] LINE_FP   = 10'(V_PULSE + V_BP + V_DISP);
    localparam logic [9:0] LINE_LAST = 10'(V_PULSE + V_BP + V_DISP + V_FP - 1);
    localparam logic [2:0] ROW_LAST  = 3'(LINES_PER_ROW - 1);
    localparam logic [6:0] VPIX_MAX  = 7'(VPIXEL_MAX);

    typedef enum logic [1:0] {
        S_SYNC,
        S_BP,
        S_DISP,
        S_FP
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] line_q, line_d;
    logic [2:0] row_q, row_d;
    logic [6:0] vpixel_q, vpixel_d;
    logic       vsync_q, vsync_d;
    logic       v_active_q, v_active_d;
    logic       frame_start_q, frame_start_d;
`ifdef VSYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;
`endif

    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        row_d         = row_q;
        vpixel_d      = vpixel_q;
        vsync_d       = vsync_q;
        v_active_d    = v_active_q;
        frame_start_d = 1'b0;

        if (line_end) begin
            if (line_q == LINE_LAST) begin
                line_d        = 10'd0;
                frame_start_d = 1'b1;
            end else begin
                line_d = line_q + 10'd1;
            end

            // Region changes are decided on the line being entered, so the
            // outputs computed below already describe the new scanline.
            case (state_q)
                S_SYNC:  if (line_d == LINE_BP)   state_d = S_BP;
                S_BP:    if (line_d == LINE_DISP) state_d = S_DISP;
                S_DISP:  if (line_d == LINE_FP)   state_d = S_FP;
                S_FP:    if (line_d == 10'd0)     state_d = S_SYNC;
                default: state_d = S_SYNC;
            endcase

            vsync_d    = (state_d != S_SYNC);
            v_active_d = (state_d == S_DISP);

            // Row stepping only happens between two display lines; entering
            // or leaving the display region parks both counters at zero.
            if (state_q == S_DISP && state_d == S_DISP) begin
                if (row_q == ROW_LAST) begin
                    row_d = 3'd0;
                    if (vpixel_q != VPIX_MAX) begin
                        vpixel_d = vpixel_q + 7'd1;
                    end
                end else begin
                    row_d = row_q + 3'd1;
                end
            end else begin
                row_d    = 3'd0;
                vpixel_d = 7'd0;
            end
        end
    end

`ifdef VSYNC_FRAME_CNT_EN
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end
`endif

    // Reset restarts the frame in the sync pulse, matching the horizontal
    // block, and deliberately does not raise frame_start on exit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_SYNC;
            line_q        <= 10'd0;
            row_q         <= 3'd0;
            vpixel_q      <= 7'd0;
            vsync_q       <= 1'b0;
            v_active_q    <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VSYNC_FRAME_CNT_EN
            frame_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            row_q         <= row_d;
            vpixel_q      <= vpixel_d;
            vsync_q       <= vsync_d;
            v_active_q    <= v_active_d;
            frame_start_q <= frame_start_d;
`ifdef VSYNC_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign VPIXEL      = vpixel_q;
    assign VGA_VSYNC   = vsync_q;
    assign v_active    = v_active_q;
    assign frame_start = frame_start_q;
`ifdef VSYNC_FRAME_CNT_EN
    assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vsync.sv
// ---------------------------------------------------------------------------
// tb_vsync -- scoreboard bench for the vertical timing generator.
//
// The stimulus side pushes the expected outputs for every clock that should
// change them (a reset cycle or a consumed line_end). The monitor pops one
// entry for each such clock and compares; on all other clocks it checks that
// the outputs hold and that frame_start has dropped. Landmark lines use
// hand-computed values, the rest come from a line-number model.
// Scanlines are shortened to a few clocks to keep the run short.
// ---------------------------------------------------------------------------
module tb_vsync;

    typedef struct packed {
        logic       vsync;
        logic       active;
        logic [6:0] vpixel;
        logic       fs;
        logic [7:0] frames;
    } exp_t;

    logic       clk = 1'b1;
    logic       reset;
    logic       line_end;
    logic [6:0] VPIXEL;
    logic       VGA_VSYNC;
    logic       v_active;
    logic       frame_start;
`ifdef VSYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    vsync dut (
        .clk         (clk),
        .reset       (reset),
        .line_end    (line_end),
        .VPIXEL      (VPIXEL),
        .VGA_VSYNC   (VGA_VSYNC),
        .v_active    (v_active),
        .frame_start (frame_start)
`ifdef VSYNC_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    m_line = 0;
    int    m_frames = 0;
    bit    started = 1'b0;

    // Hand-computed landmark lines: {vsync, active, vpixel, frame_start}.
    function automatic bit handValue(input int ln, output logic [9:0] v, output string t);
        handValue = 1'b1;
        case (ln)
            0:       begin v = {1'b0, 1'b0, 7'd0,  1'b1}; t = "wrap_frame_start"; end
            2:       begin v = {1'b1, 1'b0, 7'd0,  1'b0}; t = "line2_vsync_high"; end
            31:      begin v = {1'b1, 1'b1, 7'd0,  1'b0}; t = "line31_disp_start"; end
            36:      begin v = {1'b1, 1'b1, 7'd1,  1'b0}; t = "line36_row1"; end
            300:     begin v = {1'b1, 1'b1, 7'd53, 1'b0}; t = "line300_row53"; end
            510:     begin v = {1'b1, 1'b1, 7'd95, 1'b0}; t = "line510_row95"; end
            511:     begin v = {1'b1, 1'b0, 7'd0,  1'b0}; t = "line511_fp"; end
            default: begin v = 10'd0; t = "line"; handValue = 1'b0; end
        endcase
    endfunction

    task automatic checkOutput(input exp_t e, input string t);
        exp_t act;
        act.vsync  = VGA_VSYNC;
        act.active = v_active;
        act.vpixel = VPIXEL;
        act.fs     = frame_start;
`ifdef VSYNC_FRAME_CNT_EN
        act.frames = frame_cnt;
`else
        act.frames = 8'd0;
`endif
        checks++;
        if (act !== e) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got vsync=%b act=%b vpixel=%0d fs=%b frames=%0d, expected vsync=%b act=%b vpixel=%0d fs=%b frames=%0d",
                     t, $time, act.vsync, act.active, act.vpixel, act.fs, act.frames,
                     e.vsync, e.active, e.vpixel, e.fs, e.frames);
        end
    endtask

    // Drive one clock of inputs and queue the response that clock must give.
    task automatic applyStimulus(input bit rst_n, input bit le);
        exp_t        e;
        logic [9:0]  hv;
        string       t;
        int          old;
        @(negedge clk);
        reset    = rst_n;
        line_end = le;
        if (!rst_n) begin
            m_line   = 0;
            m_frames = 0;
            e        = '0;
            exp_q.push_back(e);
            tag_q.push_back("reset");
        end else if (le) begin
            old    = m_line;
            m_line = (old == 520) ? 0 : old + 1;
            if (old == 520) m_frames = (m_frames + 1) % 256;
            e.vsync  = (m_line >= 2);
            e.active = (m_line >= 31 && m_line <= 510);
            e.vpixel = e.active ? 7'((m_line - 31) / 5) : 7'd0;
            e.fs     = (old == 520);
            e.frames = 8'(m_frames);
`ifndef VSYNC_FRAME_CNT_EN
            e.frames = 8'd0;
`endif
            if (handValue(m_line, hv, t)) begin
                {e.vsync, e.active, e.vpixel, e.fs} = hv;
            end
            exp_q.push_back(e);
            tag_q.push_back(t);
        end
    endtask

    // Monitor: an update clock pops one expectation; any other clock must hold.
    exp_t  mon_last;
    exp_t  mon_e;
    string mon_t;
    bit    mon_ev;
    always @(posedge clk) begin
        mon_ev = (reset === 1'b0) || (line_end === 1'b1);
        #1;
        if (mon_ev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_underflow @%0t: got empty queue, expected an entry", $time);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                checkOutput(mon_e, mon_t);
                mon_last    = mon_e;
                mon_last.fs = 1'b0;
                started     = 1'b1;
            end
        end else if (started) begin
            checkOutput(mon_last, "hold");
        end
    end

    initial begin
        // Reset with line_end high (must be ignored), then 100 idle clocks.
        repeat (3) applyStimulus(1'b0, 1'b1);
        repeat (100) applyStimulus(1'b1, 1'b0);

        // Two full frames of single-cycle strobes, four clocks per scanline.
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 521; p++) begin
                applyStimulus(1'b1, 1'b1);
                repeat (3) applyStimulus(1'b1, 1'b0);
            end
        end

        // line_end tied high: frame_start follows the 521st consumed strobe.
        repeat (2) applyStimulus(1'b0, 1'b0);
        repeat (600) applyStimulus(1'b1, 1'b1);

        // Mid-frame reset at line 300 (row 53), then counting restarts.
        applyStimulus(1'b0, 1'b0);
        repeat (300) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        for (int p = 0; p < 40; p++) begin
            applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b1, 1'b0);
        end

        repeat (5) applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
